// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, transmitter state encoding and parity helper.
package ps2_pkg;

  localparam logic PS2_START_BIT  = 1'b0;
  localparam logic PS2_STOP_BIT   = 1'b1;
  localparam int   PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } ps2_state_e;

  function automatic logic ps2_odd_parity(input logic [7:0] i_byte);
    return ~^i_byte;
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; flags come straight from the pointer registers.
module ps2_sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 3
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  // Resetting only the pointers is enough to discard the contents.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Keyboard-side PS/2 transmitter: buffers scan codes and serialises 11-bit frames
// on self-generated clock/data lines.
//   state | meaning
//   IDLE  | waiting for a byte; pops and loads the frame
//   HIGH  | clock high, current bit driven
//   LOW   | clock low, data held for the host to sample
//   GAP   | lines idle-high after the stop bit
module ps2_keyboard_tx #(
  parameter int HALF_CYC = 4,
  parameter int GAP_CYC  = 8,
  parameter int FIFO_AW  = 3
) (
  input  logic       i_clk,
  input  logic       i_clr_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_ps2_clk,
  output logic       o_ps2_data,
  output logic       o_busy
);
  import ps2_pkg::*;

  localparam int               CNT_MAX  = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int               CNT_W    = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                r_state;
  ps2_state_e                w_state_nxt;
  logic [CNT_W-1:0]          r_phase;
  logic [3:0]                r_bit_idx;
  logic [PS2_FRAME_BITS-1:0] r_shift;
  logic                      r_ps2_clk;
  logic                      r_ps2_data;
  logic                      r_busy;
  logic                      w_ps2_clk_nxt;
  logic                      w_ps2_data_nxt;
  logic                      w_busy_nxt;
  logic [7:0]                w_fifo_data;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_phase_done;

  assign w_push       = i_valid & ~w_full;
  assign w_pop        = (r_state == ST_IDLE) & ~w_empty;
  assign w_phase_done = (r_phase == '0);

  assign o_ready    = ~w_full;
  assign o_ps2_clk  = r_ps2_clk;
  assign o_ps2_data = r_ps2_data;
  assign o_busy     = r_busy;

  ps2_sync_fifo #(
    .WIDTH  (8),
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_clr_n(i_clr_n),
    .i_push (w_push),
    .i_data (i_data),
    .i_pop  (w_pop),
    .o_data (w_fifo_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // Line outputs are registered from the state, so they trail it by one cycle.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state    <= ST_IDLE;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ps2_clk  <= w_ps2_clk_nxt;
      r_ps2_data <= w_ps2_data_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty) w_state_nxt = ST_HIGH;
      ST_HIGH: if (w_phase_done) w_state_nxt = ST_LOW;
      ST_LOW: begin
        if (w_phase_done) begin
          if (r_bit_idx < LAST_BIT) w_state_nxt = ST_HIGH;
          else                      w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  if (w_phase_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ps2_clk_nxt  = 1'b1;
    w_ps2_data_nxt = 1'b1;
    w_busy_nxt     = 1'b0;
    case (r_state)
      ST_HIGH: begin
        w_ps2_data_nxt = r_shift[0];
        w_busy_nxt     = 1'b1;
      end
      ST_LOW: begin
        w_ps2_clk_nxt  = 1'b0;
        w_ps2_data_nxt = r_shift[0];
        w_busy_nxt     = 1'b1;
      end
      ST_GAP:  w_busy_nxt = 1'b1;
      default: w_busy_nxt = 1'b0;
    endcase
  end

  // Shift happens only on the LOW->HIGH transition, so data never moves while clock is low.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_phase   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift   <= {PS2_STOP_BIT, ps2_odd_parity(w_fifo_data), w_fifo_data, PS2_START_BIT};
            r_bit_idx <= '0;
            r_phase   <= HALF_LD;
          end
        end
        ST_HIGH: begin
          if (w_phase_done) r_phase <= HALF_LD;
          else              r_phase <= r_phase - 1'b1;
        end
        ST_LOW: begin
          if (w_phase_done) begin
            if (r_bit_idx < LAST_BIT) begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_shift   <= {1'b1, r_shift[PS2_FRAME_BITS-1:1]};
              r_phase   <= HALF_LD;
            end else begin
              r_phase <= GAP_LD;
            end
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        ST_GAP: begin
          if (!w_phase_done) r_phase <= r_phase - 1'b1;
        end
        default: r_phase <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench: a falling-edge host decoder rebuilds frames from the PS/2 lines
// and the main sequence compares them with hand-computed bytes, bits and cycle offsets.
module tb_ps2_keyboard_tx;

  localparam int HALF = 4;
  localparam int GAP  = 8;
  localparam int AW   = 3;

  logic       i_clk   = 1'b0;
  logic       i_clr_n = 1'b0;
  logic [7:0] i_data  = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       o_ps2_clk;
  logic       o_ps2_data;
  logic       o_busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  ps2_keyboard_tx #(
    .HALF_CYC(HALF),
    .GAP_CYC (GAP),
    .FIFO_AW (AW)
  ) dut (
    .i_clk     (i_clk),
    .i_clr_n   (i_clr_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_ps2_clk (o_ps2_clk),
    .o_ps2_data(o_ps2_data),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Host-side receiver: samples data on every falling edge of the PS/2 clock.
  logic [7:0]  q_byte[$];
  logic [10:0] q_bits[$];
  logic        q_ok[$];
  int          q_fall[$];
  int          nb         = 0;
  logic [10:0] sh         = '0;
  logic        prev_clk   = 1'b1;
  logic        prev_data  = 1'b1;
  int          prev_fall  = 0;
  int          first_fall = 0;
  int          bad_intv   = 0;
  int          bad_chg    = 0;

  always @(negedge i_clk) begin
    if (!i_clr_n) begin
      nb = 0;
    end else begin
      if (prev_clk && !o_ps2_clk) begin
        if (nb > 0 && (cyc - prev_fall) != 2 * HALF) bad_intv++;
        if (nb == 0) first_fall = cyc;
        prev_fall = cyc;
        sh[nb] = o_ps2_data;
        nb++;
        if (nb == 11) begin
          q_bits.push_back(sh);
          q_byte.push_back(sh[8:1]);
          q_ok.push_back(sh[0] == 1'b0 && sh[10] == 1'b1 && sh[9] == ~^sh[8:1]);
          q_fall.push_back(first_fall);
          nb = 0;
        end
      end
      if (!o_ps2_clk && (o_ps2_data !== prev_data)) bad_chg++;
    end
    prev_clk  = o_ps2_clk;
    prev_data = o_ps2_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qbyte(input int i);
    return (i < q_byte.size()) ? 32'(q_byte[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] qbits(input int i);
    return (i < q_bits.size()) ? 32'(q_bits[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] qok(input int i);
    return (i < q_ok.size()) ? 32'(q_ok[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] qfall(input int i);
    return (i < q_fall.size()) ? 32'(q_fall[i]) : 32'hDEAD;
  endfunction

  task automatic clear_q();
    q_byte.delete();
    q_bits.delete();
    q_ok.delete();
    q_fall.delete();
  endtask

  task automatic push1(input logic [7:0] b);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = b;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while ((q_byte.size() < n || o_busy) && t < budget) begin
      @(negedge i_clk);
      t++;
    end
    chk("frame_count", 32'(q_byte.size()), 32'(n));
  endtask

  logic [7:0] par_in  [3] = '{8'h00, 8'hFF, 8'h01};
  logic       par_exp [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] loop_in [3] = '{8'h1C, 8'hF0, 8'h1C};

  initial begin
    int          e0;
    int          t;
    int          acc;
    logic        rdy7;
    logic        rdy8;
    logic [31:0] bits;
    logic [7:0]  b;

    // reset state
    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_clk",   32'(o_ps2_clk), 32'd1);
    chk("rst_data",  32'(o_ps2_data), 32'd1);
    chk("rst_busy",  32'(o_busy), 32'd0);
    i_clr_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // single frame 0x1C with timing
    clear_q();
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = 8'h1C;
    @(negedge i_clk);
    i_valid = 1'b0;
    e0 = cyc;
    @(negedge i_clk);
    chk("e1_busy", 32'(o_busy), 32'd0);
    chk("e1_data", 32'(o_ps2_data), 32'd1);
    @(negedge i_clk);
    chk("e2_busy", 32'(o_busy), 32'd1);
    chk("e2_data", 32'(o_ps2_data), 32'd0);
    chk("e2_clk",  32'(o_ps2_clk), 32'd1);
    t = cyc - e0;
    while (o_busy && t < 400) begin
      @(negedge i_clk);
      t = cyc - e0;
    end
    chk("busy_fall", 32'(t), 32'd98);
    chk("f1_count", 32'(q_byte.size()), 32'd1);
    chk("f1_bits",  qbits(0), 32'h438);
    chk("f1_byte",  qbyte(0), 32'h1C);
    chk("f1_fall",  qfall(0) - 32'(e0), 32'd6);

    // parity cases
    for (int i = 0; i < 3; i++) begin
      clear_q();
      push1(par_in[i]);
      wait_frames(1, 300);
      bits = qbits(0);
      chk("par_byte", qbyte(0), 32'(par_in[i]));
      chk("par_bit",  32'(bits[9]), 32'(par_exp[i]));
    end

    // fill: valid held high for 12 edges, only 9 should land
    clear_q();
    acc  = 0;
    rdy7 = 1'b0;
    rdy8 = 1'b1;
    @(negedge i_clk);
    e0 = cyc;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge i_clk);
      if (k == 8) rdy7 = o_ready;
      if (k == 9) rdy8 = o_ready;
      if (o_ready) acc++;
      i_valid = 1'b1;
      i_data  = 8'h10 + 8'(k);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("fill_acc",  32'(acc), 32'd9);
    chk("rdy_e7",    32'(rdy7), 32'd1);
    chk("rdy_e8",    32'(rdy8), 32'd0);
    t = cyc - e0 - 1;
    while (!o_ready && t < 400) begin
      @(negedge i_clk);
      t = cyc - e0 - 1;
    end
    chk("rdy_return", 32'(t), 32'd98);
    wait_frames(9, 1200);
    for (int i = 0; i < 9; i++) begin
      chk("fill_byte", qbyte(i), 32'h10 + 32'(i));
      chk("fill_ok",   qok(i), 32'd1);
    end

    // loopback sequence
    clear_q();
    for (int i = 0; i < 3; i++) push1(loop_in[i]);
    wait_frames(3, 500);
    for (int i = 0; i < 3; i++) begin
      chk("loop_byte", qbyte(i), 32'(loop_in[i]));
      chk("loop_ok",   qok(i), 32'd1);
    end

    // reset mid-frame with bytes still queued
    clear_q();
    push1(8'h55);
    e0 = cyc;
    push1(8'h66);
    push1(8'h77);
    while ((cyc - e0) < 30) @(negedge i_clk);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    i_clr_n = 1'b0;
    #1;
    chk("abort_clk",   32'(o_ps2_clk), 32'd1);
    chk("abort_data",  32'(o_ps2_data), 32'd1);
    chk("abort_busy",  32'(o_busy), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    repeat (2) @(negedge i_clk);
    i_clr_n = 1'b1;
    clear_q();
    repeat (150) @(negedge i_clk);
    chk("flushed_frames", 32'(q_byte.size()), 32'd0);
    chk("flushed_busy",   32'(o_busy), 32'd0);
    push1(8'h32);
    wait_frames(1, 300);
    chk("post_rst_byte", qbyte(0), 32'h32);
    chk("post_rst_ok",   qok(0), 32'd1);

    // pointer wrap: 20 bytes spaced 100 cycles apart
    clear_q();
    for (int i = 0; i < 20; i++) begin
      b = 8'hA0 + 8'(i * 3);
      push1(b);
      repeat (98) @(negedge i_clk);
    end
    wait_frames(20, 400);
    for (int i = 0; i < 20; i++) begin
      chk("wrap_byte", qbyte(i), 32'hA0 + 32'(i * 3));
    end

    chk("bit_interval", 32'(bad_intv), 32'd0);
    chk("data_low_chg", 32'(bad_chg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
